// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-size codes and FSM state encoding.
package mem_stage_pkg;

    // Access size codes carried on mem_size_i (2'b11 behaves as a word).
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    // MEM stage sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
//
// Handshake: the master raises dmem_req_o and keeps addr/we/be/wdata
// constant until it samples dmem_gnt_i high on a rising clock edge; that
// edge completes the request. For reads the slave later returns exactly
// one dmem_rvalid_i pulse with dmem_rdata_i valid in the same cycle.
// gnt is only meaningful while req is high, rvalid only while a read is
// outstanding.
interface mem_stage_if #(
    parameter int ADDR_W = 32
) ();
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [3:0]        dmem_be_o;
    logic [31:0]       dmem_wdata_o;
    logic              dmem_gnt_i;
    logic              dmem_rvalid_i;
    logic [31:0]       dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte-enables / lane replication /
// misalignment detection, and load lane extraction with sign/zero extension.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_addr_lo_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    // Store side: enable the addressed lanes and replicate the data across them.
    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = st_data_i;
        misalign_o = 1'b0;
        case (st_size_i)
            MEM_B: begin
                be_o    = 4'b0001 << st_addr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            MEM_H: begin
                be_o       = 4'b0011 << st_addr_lo_i;
                wdata_o    = {2{st_data_i[15:0]}};
                misalign_o = st_addr_lo_i[0];
            end
            default: begin
                misalign_o = |st_addr_lo_i;
            end
        endcase
    end

    assign ld_shifted = rdata_i >> {ld_addr_lo_i, 3'b000};

    // Load side: take the addressed lanes down to bit 0 and extend to 32 bits.
    always_comb begin
        ld_data_o = ld_shifted;
        case (ld_size_i)
            MEM_B: ld_data_o = ld_unsigned_i ? {24'd0, ld_shifted[7:0]}
                                             : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            MEM_H: ld_data_o = ld_unsigned_i ? {16'd0, ld_shifted[15:0]}
                                             : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: sequences loads/stores on the data bus,
// passes ALU results through, and drives the MEM/WB payload and stall.
// ADDR_W must not exceed 32 (the address comes from the 32-bit ALU result).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    input  logic        wb_en_i,
    input  logic        read_en_i,
    input  logic        update_en_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    mem_stage_if.master dmem,
    output logic        wb_valid_o,
    output logic        wb_en_o,
    output logic [4:0]  rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        stall_o,
    output mem_state_e  state_o
);

    mem_state_e state_q, state_d;

    // Latched request (held stable for the whole bus transaction)
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [4:0]        req_rd_q, req_rd_d;
    logic              req_wb_en_q, req_wb_en_d;

    // MEM/WB payload registers
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;

    logic              op_present;
    logic              mem_op;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic              al_misalign;
    logic [31:0]       ld_data;

    assign op_present = wb_en_i | read_en_i | update_en_i;
    assign mem_op     = read_en_i | update_en_i;

    lsu_align u_align (
        .st_addr_lo_i  (result_i[1:0]),
        .st_size_i     (mem_size_i),
        .st_data_i     (store_data_i),
        .be_o          (al_be),
        .wdata_o       (al_wdata),
        .misalign_o    (al_misalign),
        .ld_addr_lo_i  (addr_lo_q),
        .ld_size_i     (size_q),
        .ld_unsigned_i (uns_q),
        .rdata_i       (dmem.dmem_rdata_i),
        .ld_data_o     (ld_data)
    );

    // Next-state and next-register logic; IDLE and DONE both accept a new op.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        addr_lo_d   = addr_lo_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        req_rd_d    = req_rd_q;
        req_wb_en_d = req_wb_en_q;
        wb_valid_d  = 1'b0;
        wb_en_d     = wb_en_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        misalign_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (op_present) begin
                    if (mem_op) begin
                        if (al_misalign) begin
                            misalign_d = 1'b1;
                        end else begin
                            addr_d      = {result_i[ADDR_W-1:2], 2'b00};
                            addr_lo_d   = result_i[1:0];
                            be_d        = al_be;
                            wdata_d     = al_wdata;
                            we_d        = update_en_i & ~read_en_i;
                            size_d      = mem_size_i;
                            uns_d       = mem_unsigned_i;
                            req_rd_d    = rd_i;
                            req_wb_en_d = wb_en_i;
                            state_d     = ST_REQ;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = wb_en_i;
                        wb_rd_d    = rd_i;
                        wb_data_d  = result_i;
                    end
                end
            end
            ST_REQ: begin
                if (dmem.dmem_gnt_i) begin
                    if (we_q) begin
                        state_d    = ST_DONE;
                        wb_valid_d = 1'b1;
                        wb_en_d    = 1'b0;
                        wb_rd_d    = req_rd_q;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_rvalid_i) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    wb_en_d    = req_wb_en_q;
                    wb_rd_d    = req_rd_q;
                    wb_data_d  = ld_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and payload registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            addr_lo_q   <= 2'b00;
            be_q        <= 4'b0000;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            req_rd_q    <= 5'd0;
            req_wb_en_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addr_lo_q   <= addr_lo_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            req_rd_q    <= req_rd_d;
            req_wb_en_q <= req_wb_en_d;
            wb_valid_q  <= wb_valid_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            misalign_q  <= misalign_d;
        end
    end

    assign dmem.dmem_req_o   = (state_q == ST_REQ);
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_be_o    = be_q;
    assign dmem.dmem_wdata_o = wdata_q;

    assign stall_o    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign wb_valid_o = wb_valid_q;
    assign wb_en_o    = wb_en_q;
    assign rd_o       = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign misalign_o = misalign_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single transactions plus
// hand-written sequences for gnt delay, reset in WAIT and back-to-back ops.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] result_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        wb_en_i = 1'b0;
    logic        read_en_i = 1'b0;
    logic        update_en_i = 1'b0;
    logic [1:0]  mem_size_i = '0;
    logic        mem_unsigned_i = 1'b0;
    logic        wb_valid_o, wb_en_o, misalign_o, stall_o;
    logic [4:0]  rd_o;
    logic [31:0] wb_data_o;
    mem_state_e  state_o;

    mem_stage_if #(.ADDR_W(32)) bus ();

    mem_stage #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .result_i       (result_i),
        .store_data_i   (store_data_i),
        .rd_i           (rd_i),
        .wb_en_i        (wb_en_i),
        .read_en_i      (read_en_i),
        .update_en_i    (update_en_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .dmem           (bus),
        .wb_valid_o     (wb_valid_o),
        .wb_en_o        (wb_en_o),
        .rd_o           (rd_o),
        .wb_data_o      (wb_data_o),
        .misalign_o     (misalign_o),
        .stall_o        (stall_o),
        .state_o        (state_o)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic [31:0] sdata;
        logic [1:0]  size;
        logic        uns;
        logic        rd_en;
        logic        up_en;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        result_i       = '0;
        store_data_i   = '0;
        rd_i           = '0;
        wb_en_i        = 1'b0;
        read_en_i      = 1'b0;
        update_en_i    = 1'b0;
        mem_size_i     = '0;
        mem_unsigned_i = 1'b0;
    endtask

    task automatic drive_op(input logic [31:0] res, input logic [31:0] sd, input logic [1:0] sz,
                            input logic uns, input logic rde, input logic upe, input logic wbe,
                            input logic [4:0] rd);
        result_i       = res;
        store_data_i   = sd;
        mem_size_i     = sz;
        mem_unsigned_i = uns;
        read_en_i      = rde;
        update_en_i    = upe;
        wb_en_i        = wbe;
        rd_i           = rd;
    endtask

    // Apply one table vector with zero-wait gnt and rvalid; entered just after a rising edge.
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = v.result & 32'hFFFF_FFFC;
        drive_op(v.result, v.sdata, v.size, v.uns, v.rd_en, v.up_en, v.wb_en, v.rd);
        next_cycle();
        clear_op();
        if (v.mis) begin
            @(negedge clk);
            check({v.name, ".misalign"}, 32'(misalign_o), 32'd1);
            check({v.name, ".req"}, 32'(bus.dmem_req_o), 32'd0);
            check({v.name, ".wb_valid"}, 32'(wb_valid_o), 32'd0);
            check({v.name, ".state"}, 32'(state_o), 32'(ST_IDLE));
            next_cycle();
            @(negedge clk);
            check({v.name, ".misalign_pulse"}, 32'(misalign_o), 32'd0);
            check({v.name, ".req_later"}, 32'(bus.dmem_req_o), 32'd0);
        end else if (!v.rd_en && !v.up_en) begin
            @(negedge clk);
            check({v.name, ".wb_valid"}, 32'(wb_valid_o), 32'd1);
            check({v.name, ".wb_data"}, wb_data_o, v.exp_data);
            check({v.name, ".rd"}, 32'(rd_o), 32'(v.rd));
            check({v.name, ".wb_en"}, 32'(wb_en_o), 32'(v.wb_en));
            check({v.name, ".stall"}, 32'(stall_o), 32'd0);
        end else begin
            bus.dmem_gnt_i = 1'b1;
            @(negedge clk);
            check({v.name, ".req"}, 32'(bus.dmem_req_o), 32'd1);
            check({v.name, ".we"}, 32'(bus.dmem_we_o), 32'(v.up_en & ~v.rd_en));
            check({v.name, ".addr"}, bus.dmem_addr_o, exp_addr);
            check({v.name, ".be"}, 32'(bus.dmem_be_o), 32'(v.exp_be));
            if (v.up_en) check({v.name, ".wdata"}, bus.dmem_wdata_o, v.exp_wdata);
            check({v.name, ".stall_req"}, 32'(stall_o), 32'd1);
            next_cycle();
            bus.dmem_gnt_i = 1'b0;
            if (v.rd_en) begin
                bus.dmem_rvalid_i = 1'b1;
                bus.dmem_rdata_i  = v.rdata;
                @(negedge clk);
                check({v.name, ".state_wait"}, 32'(state_o), 32'(ST_WAIT));
                check({v.name, ".req_wait"}, 32'(bus.dmem_req_o), 32'd0);
                check({v.name, ".stall_wait"}, 32'(stall_o), 32'd1);
                check({v.name, ".wb_valid_wait"}, 32'(wb_valid_o), 32'd0);
                next_cycle();
                bus.dmem_rvalid_i = 1'b0;
                bus.dmem_rdata_i  = '0;
            end
            @(negedge clk);
            check({v.name, ".wb_valid"}, 32'(wb_valid_o), 32'd1);
            check({v.name, ".wb_en"}, 32'(wb_en_o), v.rd_en ? 32'(v.wb_en) : 32'd0);
            check({v.name, ".stall_done"}, 32'(stall_o), 32'd0);
            if (v.rd_en) begin
                check({v.name, ".wb_data"}, wb_data_o, v.exp_data);
                check({v.name, ".rd"}, 32'(rd_o), 32'(v.rd));
            end
        end
        next_cycle();
        @(negedge clk);
        check({v.name, ".wb_valid_idle"}, 32'(wb_valid_o), 32'd0);
        check({v.name, ".state_idle"}, 32'(state_o), 32'(ST_IDLE));
        next_cycle();
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_cnt;
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = '0;

        //            name       result        sdata         size   uns rde upe wbe rd     rdata         mis be       wdata         data
        vecs[0]  = '{"alu",      32'h0000_1234, 32'h0,        MEM_W, 0, 0, 0, 1, 5'd5,  32'h0,        0, 4'b0000, 32'h0,        32'h0000_1234};
        vecs[1]  = '{"lb_s",     32'h0000_0103, 32'h0,        MEM_B, 0, 1, 0, 1, 5'd3,  32'h80FF_0000, 0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{"lbu",      32'h0000_0101, 32'h0,        MEM_B, 1, 1, 0, 1, 5'd4,  32'h0000_9A00, 0, 4'b0010, 32'h0,        32'h0000_009A};
        vecs[3]  = '{"lh_s",     32'h0000_0102, 32'h0,        MEM_H, 0, 1, 0, 1, 5'd6,  32'h8001_1234, 0, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[4]  = '{"lhu",      32'h0000_0100, 32'h0,        MEM_H, 1, 1, 0, 1, 5'd8,  32'h1234_F00D, 0, 4'b0011, 32'h0,        32'h0000_F00D};
        vecs[5]  = '{"lw",       32'h0000_0204, 32'h0,        MEM_W, 0, 1, 0, 1, 5'd9,  32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[6]  = '{"lw_sz3",   32'h0000_0110, 32'h0,        2'b11, 0, 1, 0, 1, 5'd10, 32'h1357_9BDF, 0, 4'b1111, 32'h0,        32'h1357_9BDF};
        vecs[7]  = '{"lb_pos",   32'h0000_0102, 32'h0,        MEM_B, 0, 1, 0, 1, 5'd11, 32'h117F_2233, 0, 4'b0100, 32'h0,        32'h0000_007F};
        vecs[8]  = '{"sb",       32'h0000_0301, 32'h1234_56A5, MEM_B, 0, 0, 1, 1, 5'd12, 32'h0,        0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[9]  = '{"sh",       32'h0000_0206, 32'h1111_BEEF, MEM_H, 0, 0, 1, 0, 5'd0,  32'h0,        0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[10] = '{"sw",       32'h0000_0308, 32'hCAFE_F00D, MEM_W, 0, 0, 1, 0, 5'd0,  32'h0,        0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[11] = '{"mis_lh",   32'h0000_0105, 32'h0,        MEM_H, 0, 1, 0, 1, 5'd13, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{"mis_sw",   32'h0000_0102, 32'h5555_5555, MEM_W, 0, 0, 1, 0, 5'd0,  32'h0,        1, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{"mis_lw",   32'h0000_0101, 32'h0,        MEM_W, 0, 1, 0, 1, 5'd14, 32'h0,        1, 4'b0000, 32'h0,        32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", 32'(state_o), 32'(ST_IDLE));
        check("rst.req", 32'(bus.dmem_req_o), 32'd0);
        check("rst.wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst.stall", 32'(stall_o), 32'd0);
        check("rst.misalign", 32'(misalign_o), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) run_vec(vecs[i]);

        // SH with gnt held off for three cycles: request must stay put.
        stall_cnt = 0;
        drive_op(32'h0000_0202, 32'h0000_ABCD, MEM_H, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        next_cycle();
        clear_op();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.dmem_gnt_i = 1'b1;
            @(negedge clk);
            check("sh_gnt.req", 32'(bus.dmem_req_o), 32'd1);
            check("sh_gnt.addr", bus.dmem_addr_o, 32'h0000_0200);
            check("sh_gnt.be", 32'(bus.dmem_be_o), 32'b1100);
            check("sh_gnt.wdata", bus.dmem_wdata_o, 32'hABCD_ABCD);
            if (stall_o) stall_cnt++;
            next_cycle();
        end
        bus.dmem_gnt_i = 1'b0;
        check("sh_gnt.stall_cycles", 32'(stall_cnt), 32'd4);
        @(negedge clk);
        check("sh_gnt.wb_valid", 32'(wb_valid_o), 32'd1);
        check("sh_gnt.wb_en", 32'(wb_en_o), 32'd0);
        check("sh_gnt.stall_done", 32'(stall_o), 32'd0);
        next_cycle();
        @(negedge clk);
        check("sh_gnt.wb_valid_idle", 32'(wb_valid_o), 32'd0);
        next_cycle();

        // Reset while waiting for read data; a late rvalid must be ignored.
        drive_op(32'h0000_0100, 32'h0, MEM_W, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2);
        next_cycle();
        clear_op();
        bus.dmem_gnt_i = 1'b1;
        next_cycle();
        bus.dmem_gnt_i = 1'b0;
        @(negedge clk);
        check("rstw.state_wait", 32'(state_o), 32'(ST_WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw.state", 32'(state_o), 32'(ST_IDLE));
        check("rstw.req", 32'(bus.dmem_req_o), 32'd0);
        check("rstw.stall", 32'(stall_o), 32'd0);
        check("rstw.addr", bus.dmem_addr_o, 32'd0);
        check("rstw.be", 32'(bus.dmem_be_o), 32'd0);
        check("rstw.we", 32'(bus.dmem_we_o), 32'd0);
        check("rstw.wdata", bus.dmem_wdata_o, 32'd0);
        check("rstw.wb_data", wb_data_o, 32'd0);
        check("rstw.wb_valid", 32'(wb_valid_o), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h1234_5678;
        @(negedge clk);
        check("rstw.state_late", 32'(state_o), 32'(ST_IDLE));
        next_cycle();
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = '0;
        @(negedge clk);
        check("rstw.wb_valid_late", 32'(wb_valid_o), 32'd0);
        check("rstw.wb_data_late", wb_data_o, 32'd0);
        next_cycle();

        // LBU followed by a held ALU op accepted straight out of DONE.
        drive_op(32'h0000_0100, 32'h0, MEM_B, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9);
        next_cycle();
        drive_op(32'h0000_0055, 32'h0, MEM_W, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
        bus.dmem_gnt_i = 1'b1;
        @(negedge clk);
        check("b2b.req", 32'(bus.dmem_req_o), 32'd1);
        check("b2b.addr", bus.dmem_addr_o, 32'h0000_0100);
        check("b2b.be", 32'(bus.dmem_be_o), 32'b0001);
        next_cycle();
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h0000_00FF;
        @(negedge clk);
        check("b2b.stall_wait", 32'(stall_o), 32'd1);
        check("b2b.wb_valid_wait", 32'(wb_valid_o), 32'd0);
        next_cycle();
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = '0;
        @(negedge clk);
        check("b2b.ld_valid", 32'(wb_valid_o), 32'd1);
        check("b2b.ld_data", wb_data_o, 32'h0000_00FF);
        check("b2b.ld_rd", 32'(rd_o), 32'd9);
        check("b2b.state_done", 32'(state_o), 32'(ST_DONE));
        next_cycle();
        clear_op();
        @(negedge clk);
        check("b2b.alu_valid", 32'(wb_valid_o), 32'd1);
        check("b2b.alu_data", wb_data_o, 32'h0000_0055);
        check("b2b.alu_rd", 32'(rd_o), 32'd7);
        check("b2b.alu_wb_en", 32'(wb_en_o), 32'd1);
        check("b2b.state_idle", 32'(state_o), 32'(ST_IDLE));
        next_cycle();
        @(negedge clk);
        check("b2b.wb_valid_end", 32'(wb_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
